// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write-port arbiter and the FIFO write side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wren;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic [IDW-1:0]                grant_id;
  logic                          busy;

  // Producer/FIFO side drives the requests and the full flag
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wren, fifo_wdata, grant_id, busy
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wren, fifo_wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting bursts of up to MAX_BURST words and never writing into a full FIFO.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CDW = IDW + 1;
  localparam int unsigned CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_last_grant;
  logic [CW-1:0]    r_burst_cnt;

  logic                  w_any_valid;
  logic [IDW-1:0]        w_pick;
  logic [CDW-1:0]        w_cand;
  logic                  w_gvalid;
  logic                  w_xfer;
  logic [NUM_REQ-1:0]    w_ready;
  logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Rotating search from last_grant+1; scanning downward lets the nearest valid index win
  always_comb begin
    w_any_valid = |bus.req_valid;
    w_pick      = '0;
    w_cand      = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      w_cand = CDW'(r_last_grant) + CDW'(k);
      if (w_cand >= CDW'(NUM_REQ)) begin
        w_cand = w_cand - CDW'(NUM_REQ);
      end
      if (bus.req_valid[IDW'(w_cand)]) begin
        w_pick = IDW'(w_cand);
      end
    end
  end

  always_comb begin
    w_ready  = '0;
    w_xfer   = 1'b0;
    w_gvalid = bus.req_valid[r_grant_id];
    if (r_state == ST_GRANT) begin
      w_ready[r_grant_id] = !bus.fifo_full;
      w_xfer              = w_gvalid & !bus.fifo_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_grant_id   <= w_pick;
            r_last_grant <= w_pick;
            r_burst_cnt  <= '0;
            r_state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // A full FIFO leaves the count untouched so the stalled word is retried
          if (!w_gvalid) begin
            r_state <= ST_IDLE;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
            if (r_burst_cnt + CW'(1) == CW'(MAX_BURST)) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.fifo_wren  = w_xfer;
  assign bus.fifo_wdata = w_words[r_grant_id];
  assign bus.grant_id   = r_grant_id;
  assign bus.busy       = (r_state == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: three instances (4x burst4, 4x burst2, 3x burst2) checked
// every cycle against a cycle-level behavioural model, plus literal FIFO/grant-order checks.
module tb_fifo_wr_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int nreq [3] = '{4, 4, 3};
  int mb   [3] = '{4, 2, 2};

  logic [3:0]  valid_v [3];
  logic [31:0] data_v  [3];
  logic        full_v  [3];
  logic [3:0]  ready_o [3];
  logic        wren_o  [3];
  logic [7:0]  wdata_o [3];
  logic [1:0]  gid_o   [3];
  logic        busy_o  [3];

  logic [7:0] words [3][4][16];
  int         cnt   [3][4];
  int         rp    [3][4];
  logic [3:0] acc   [3];

  int m_owner [3] = '{-1, -1, -1};
  int m_last  [3] = '{3, 3, 2};
  int m_gid   [3] = '{0, 0, 0};
  int m_used  [3] = '{0, 0, 0};

  int         glog [3][32];
  int         gn   [3] = '{0, 0, 0};
  logic [7:0] fq   [3][64];
  int         wcyc [3][64];
  int         fn   [3] = '{0, 0, 0};
  int         cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) if_a ();
  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) if_b ();
  fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8)) if_c ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  assign if_a.req_valid = valid_v[0];
  assign if_a.req_data  = data_v[0];
  assign if_a.fifo_full = full_v[0];
  assign if_b.req_valid = valid_v[1];
  assign if_b.req_data  = data_v[1];
  assign if_b.fifo_full = full_v[1];
  assign if_c.req_valid = valid_v[2][2:0];
  assign if_c.req_data  = data_v[2][23:0];
  assign if_c.fifo_full = full_v[2];

  assign ready_o[0] = if_a.req_ready;
  assign ready_o[1] = if_b.req_ready;
  assign ready_o[2] = {1'b0, if_c.req_ready};
  assign wren_o[0]  = if_a.fifo_wren;
  assign wren_o[1]  = if_b.fifo_wren;
  assign wren_o[2]  = if_c.fifo_wren;
  assign wdata_o[0] = if_a.fifo_wdata;
  assign wdata_o[1] = if_b.fifo_wdata;
  assign wdata_o[2] = if_c.fifo_wdata;
  assign gid_o[0]   = if_a.grant_id;
  assign gid_o[1]   = if_b.grant_id;
  assign gid_o[2]   = if_c.grant_id;
  assign busy_o[0]  = if_a.busy;
  assign busy_o[1]  = if_b.busy;
  assign busy_o[2]  = if_c.busy;

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  task automatic load(input int k, input int i, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) words[k][i][j] = base + 8'(j);
    rp[k][i]  = 0;
    cnt[k][i] = n;
  endtask

  task automatic wait_idle(input int k);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk); #2;
      done = (m_owner[k] < 0) && (valid_v[k] == 4'b0);
      for (int i = 0; i < 4; i++) if (rp[k][i] < cnt[k][i]) done = 1'b0;
    end
    if (!done) timeout_fail($sformatf("idle_u%0d", k));
  endtask

  // Producers: hold a word until accepted, then present the next
  initial begin
    for (int k = 0; k < 3; k++) begin
      valid_v[k] = '0; data_v[k] = '0; full_v[k] = 1'b0; acc[k] = '0;
      for (int i = 0; i < 4; i++) begin cnt[k][i] = 0; rp[k][i] = 0; end
    end
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (acc[k][i]) rp[k][i]++;
          valid_v[k][i] = (rp[k][i] < cnt[k][i]);
          data_v[k][i*8 +: 8] = (rp[k][i] < cnt[k][i]) ? words[k][i][rp[k][i]] : 8'h00;
        end
      end
    end
  end

  // Model: owner<0 means arbitrating; grant rotates from the last owner, bursts capped by mb
  initial begin : model_p
    int c;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) begin
          m_owner[k] = -1; m_last[k] = nreq[k] - 1; m_gid[k] = 0; m_used[k] = 0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (m_owner[k] < 0) begin
            for (int j = 1; j <= nreq[k]; j++) begin
              c = (m_last[k] + j) % nreq[k];
              if (m_owner[k] < 0 && valid_v[k][c]) begin
                m_owner[k] = c; m_last[k] = c; m_gid[k] = c; m_used[k] = 0;
                if (gn[k] < 32) begin glog[k][gn[k]] = c; gn[k]++; end
              end
            end
          end else if (!valid_v[k][m_owner[k]]) begin
            m_owner[k] = -1;
          end else if (!full_v[k]) begin
            m_used[k]++;
            if (m_used[k] == mb[k]) m_owner[k] = -1;
          end
        end
      end
    end
  end

  // Compare process, mid-cycle
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic       e_busy, e_wren;
      logic [3:0] e_ready;
      e_busy  = (m_owner[k] >= 0);
      e_ready = (e_busy && !full_v[k]) ? 4'(1 << m_owner[k]) : 4'b0;
      e_wren  = e_busy && valid_v[k][m_owner[k] & 3] && !full_v[k];
      check($sformatf("u%0d_busy", k),  32'(busy_o[k]),  32'(e_busy));
      check($sformatf("u%0d_gid", k),   32'(gid_o[k]),   32'(m_gid[k]));
      check($sformatf("u%0d_ready", k), 32'(ready_o[k]), 32'(e_ready));
      check($sformatf("u%0d_wren", k),  32'(wren_o[k]),  32'(e_wren));
      if (e_wren) check($sformatf("u%0d_wdata", k), 32'(wdata_o[k]), 32'(data_v[k][m_owner[k]*8 +: 8]));
      acc[k] = valid_v[k] & ready_o[k];
      if (wren_o[k] === 1'b1 && fn[k] < 64) begin
        fq[k][fn[k]] = wdata_o[k]; wcyc[k][fn[k]] = cyc; fn[k]++;
      end
    end
  end

  initial begin
    logic [7:0] exp0 [14];
    int         gexp0 [6];
    int         gap_exp [5];
    bit         seen;
    exp0    = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h20, 8'h21, 8'h22, 8'h23,
                8'h31, 8'h41, 8'h42, 8'h01};
    gexp0   = '{0, 0, 2, 1, 3, 0};
    gap_exp = '{1, 1, 1, 2, 1};

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_busy_u%0d", k),  32'(busy_o[k]),  32'd0);
      check($sformatf("rst_ready_u%0d", k), 32'(ready_o[k]), 32'd0);
      check($sformatf("rst_wren_u%0d", k),  32'(wren_o[k]),  32'd0);
      check($sformatf("rst_gid_u%0d", k),   32'(gid_o[k]),   32'd0);
    end

    // Single producer 6 words; round robin all four; non-pow2 requesters 2 and 0
    load(0, 0, 6, 8'h10);
    for (int i = 0; i < 4; i++) load(1, i, 4, 8'(8'h50 + 16 * i));
    load(2, 0, 2, 8'h60);
    load(2, 2, 2, 8'h80);
    wait_idle(0); wait_idle(1); wait_idle(2);

    for (int w = 0; w < 5; w++)
      check($sformatf("single_gap%0d", w), 32'(wcyc[0][w+1] - wcyc[0][w]), 32'(gap_exp[w]));

    // Full stall after the first word of producer 2
    load(0, 2, 4, 8'h20);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(posedge clk); #2;
      seen = (fn[0] >= 7);
    end
    if (!seen) timeout_fail("stall_first_write");
    full_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2 full_v[0] = 1'b0;
    wait_idle(0);

    // Early release of producer 1; producers 3 and 0 wait behind it
    load(0, 1, 1, 8'h31);
    repeat (2) @(posedge clk);
    #2;
    load(0, 0, 1, 8'h01);
    load(0, 3, 2, 8'h41);
    wait_idle(0);

    check("u0_fifo_count", 32'(fn[0]), 32'd14);
    for (int w = 0; w < 14; w++) check($sformatf("u0_fifo%0d", w), 32'(fq[0][w]), 32'(exp0[w]));
    check("u0_grant_count", 32'(gn[0]), 32'd6);
    for (int g = 0; g < 6; g++) check($sformatf("u0_grant%0d", g), 32'(glog[0][g]), 32'(gexp0[g]));

    check("rr_fifo_count", 32'(fn[1]), 32'd16);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("rr_grant%0d", b), 32'(glog[1][b]), 32'(b % 4));
      for (int t = 0; t < 2; t++)
        check($sformatf("rr_fifo%0d", 2*b+t), 32'(fq[1][2*b+t]), 32'(8'h50 + 16*(b%4) + 2*(b/4) + t));
    end

    check("np2_grant_count", 32'(gn[2]), 32'd2);
    check("np2_grant0", 32'(glog[2][0]), 32'd0);
    check("np2_grant1", 32'(glog[2][1]), 32'd2);
    check("np2_fifo0", 32'(fq[2][0]), 32'h60);
    check("np2_fifo1", 32'(fq[2][1]), 32'h61);
    check("np2_fifo2", 32'(fq[2][2]), 32'h80);
    check("np2_fifo3", 32'(fq[2][3]), 32'h81);

    // Asynchronous reset in the middle of a grant to producer 1
    load(0, 1, 8, 8'h70);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk); #2;
      seen = (busy_o[0] === 1'b1);
    end
    if (!seen) timeout_fail("midburst_busy");
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready_o[0]), 32'd0);
    check("arst_wren",  32'(wren_o[0]),  32'd0);
    check("arst_busy",  32'(busy_o[0]),  32'd0);
    check("arst_gid",   32'(gid_o[0]),   32'd0);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) begin cnt[k][i] = 0; rp[k][i] = 0; end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("post_rst_busy", 32'(busy_o[0]), 32'd0);
    check("post_rst_gid",  32'(gid_o[0]),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
